// File: rtl/vcache_perf_counter_bank.sv
// Per-bank vcache event counters (saturating, sticky sat) with atomic snapshot streamed one counter per beat.
// Latency: beat 0 valid the cycle after acceptance; backpressure holds the beat, live counting never stalls.
module vcache_perf_counter_bank #(
  parameter  int num_banks_p      = 4,
  parameter  int ctr_width_p      = 32,
  parameter  int tag_width_p      = 32,
  localparam int bank_id_width_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [6*num_banks_p-1:0]    ev_v_i,
  input  logic [31:0]                 global_ctr_i,
  input  logic                        snap_v_i,
  input  logic                        snap_clear_i,
  input  logic [tag_width_p-1:0]      snap_tag_i,
  output logic                        snap_ready_o,
  output logic                        rd_v_o,
  input  logic                        rd_ready_i,
  output logic [bank_id_width_lp-1:0] rd_bank_o,
  output logic [2:0]                  rd_event_o,
  output logic [ctr_width_p-1:0]      rd_count_o,
  output logic                        rd_sat_o,
  output logic [tag_width_p-1:0]      rd_tag_o,
  output logic [31:0]                 rd_time_o,
  output logic                        rd_last_o
);

  localparam int n_ctr_lp     = 6 * num_banks_p;
  localparam int idx_width_lp = $clog2(n_ctr_lp);

  typedef enum logic {IDLE_S, DRAIN_S} state_e;

  state_e                   state_q, state_d;
  logic [idx_width_lp-1:0]  idx_q, idx_d;
  logic [bank_id_width_lp-1:0] bank_q, bank_d;
  logic [2:0]               ev_q, ev_d;

  logic [ctr_width_p-1:0]   live_q [n_ctr_lp];
  logic [ctr_width_p-1:0]   live_d [n_ctr_lp];
  logic [ctr_width_p-1:0]   shd_q  [n_ctr_lp];
  logic [ctr_width_p-1:0]   shd_d  [n_ctr_lp];
  logic [n_ctr_lp-1:0]      sat_q, sat_d, shd_sat_q, shd_sat_d;
  logic [tag_width_p-1:0]   tag_q, tag_d;
  logic [31:0]              time_q, time_d;

  logic snap_acc, rd_hs, last_beat, draining;

  assign draining  = (state_q == DRAIN_S);
  assign snap_acc  = snap_v_i & (state_q == IDLE_S);
  assign rd_hs     = draining & rd_ready_i;
  assign last_beat = (idx_q == idx_width_lp'(n_ctr_lp - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE_S;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:  if (snap_acc) state_d = DRAIN_S;
      DRAIN_S: if (rd_hs && last_beat) state_d = IDLE_S;
      default: state_d = IDLE_S;
    endcase
  end

  always_comb begin
    snap_ready_o = (state_q == IDLE_S);
    rd_v_o       = draining;
    rd_last_o    = draining & last_beat;
    rd_bank_o    = bank_q;
    rd_event_o   = ev_q;
    rd_count_o   = draining ? shd_q[idx_q] : '0;
    rd_sat_o     = draining & shd_sat_q[idx_q];
    rd_tag_o     = tag_q;
    rd_time_o    = time_q;
  end

  // bank/event tracked alongside the flat index to avoid a divide-by-6
  always_comb begin
    idx_d  = idx_q;
    bank_d = bank_q;
    ev_d   = ev_q;
    if (snap_acc) begin
      idx_d  = '0;
      bank_d = '0;
      ev_d   = '0;
    end else if (rd_hs) begin
      if (last_beat) begin
        idx_d  = '0;
        bank_d = '0;
        ev_d   = '0;
      end else begin
        idx_d = idx_q + idx_width_lp'(1);
        if (ev_q == 3'd5) begin
          ev_d   = '0;
          bank_d = bank_q + bank_id_width_lp'(1);
        end else begin
          ev_d = ev_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < n_ctr_lp; i++) begin
      live_d[i] = live_q[i];
      sat_d[i]  = sat_q[i];
      if (snap_acc && snap_clear_i) begin
        live_d[i] = ev_v_i[i] ? ctr_width_p'(1) : '0;
        sat_d[i]  = 1'b0;
      end else if (ev_v_i[i]) begin
        if (&live_q[i]) begin
          sat_d[i] = 1'b1;
        end else begin
          live_d[i] = live_q[i] + ctr_width_p'(1);
        end
      end
    end
  end

  // shadow captures pre-event live values of the accepting cycle
  always_comb begin
    shd_sat_d = shd_sat_q;
    tag_d     = tag_q;
    time_d    = time_q;
    for (int i = 0; i < n_ctr_lp; i++) begin
      shd_d[i] = shd_q[i];
    end
    if (snap_acc) begin
      shd_sat_d = sat_q;
      tag_d     = snap_tag_i;
      time_d    = global_ctr_i;
      for (int i = 0; i < n_ctr_lp; i++) begin
        shd_d[i] = live_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q     <= '0;
      bank_q    <= '0;
      ev_q      <= '0;
      sat_q     <= '0;
      shd_sat_q <= '0;
      tag_q     <= '0;
      time_q    <= '0;
      for (int i = 0; i < n_ctr_lp; i++) begin
        live_q[i] <= '0;
        shd_q[i]  <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      bank_q    <= bank_d;
      ev_q      <= ev_d;
      sat_q     <= sat_d;
      shd_sat_q <= shd_sat_d;
      tag_q     <= tag_d;
      time_q    <= time_d;
      for (int i = 0; i < n_ctr_lp; i++) begin
        live_q[i] <= live_d[i];
        shd_q[i]  <= shd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_vcache_perf_counter_bank.sv
// Directed bench for vcache_perf_counter_bank: 2 banks, 8-bit counters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_vcache_perf_counter_bank;

  localparam int NB = 2;
  localparam int CW = 8;
  localparam int TW = 32;
  localparam int N  = 6 * NB;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [N-1:0]  ev_v_i;
  logic [31:0]   global_ctr_i = 32'h100;
  logic          snap_v_i;
  logic          snap_clear_i;
  logic [TW-1:0] snap_tag_i;
  logic          snap_ready_o;
  logic          rd_v_o;
  logic          rd_ready_i;
  logic [0:0]    rd_bank_o;
  logic [2:0]    rd_event_o;
  logic [CW-1:0] rd_count_o;
  logic          rd_sat_o;
  logic [TW-1:0] rd_tag_o;
  logic [31:0]   rd_time_o;
  logic          rd_last_o;

  int            vectors = 0;
  int            errors  = 0;
  int            exp_c [N];
  logic [N-1:0]  exp_s;
  logic [31:0]   tm;

  vcache_perf_counter_bank #(
    .num_banks_p(NB),
    .ctr_width_p(CW),
    .tag_width_p(TW)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .ev_v_i      (ev_v_i),
    .global_ctr_i(global_ctr_i),
    .snap_v_i    (snap_v_i),
    .snap_clear_i(snap_clear_i),
    .snap_tag_i  (snap_tag_i),
    .snap_ready_o(snap_ready_o),
    .rd_v_o      (rd_v_o),
    .rd_ready_i  (rd_ready_i),
    .rd_bank_o   (rd_bank_o),
    .rd_event_o  (rd_event_o),
    .rd_count_o  (rd_count_o),
    .rd_sat_o    (rd_sat_o),
    .rd_tag_o    (rd_tag_o),
    .rd_time_o   (rd_time_o),
    .rd_last_o   (rd_last_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) global_ctr_i <= global_ctr_i + 32'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < N; i++) exp_c[i] = 0;
    exp_s = '0;
  endtask

  task automatic pulse(input int idx, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      ev_v_i = N'(1) << idx;
      tick();
    end
    ev_v_i = '0;
  endtask

  task automatic snap(input logic [31:0] tag, input logic clr, input logic [N-1:0] ev,
                      output logic [31:0] t);
    int n = 0;
    while (!snap_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("snap_ready_wait", 64'(snap_ready_o), 64'd1);
    snap_v_i     = 1'b1;
    snap_tag_i   = tag;
    snap_clear_i = clr;
    ev_v_i       = ev;
    t            = global_ctr_i;
    tick();
    snap_v_i     = 1'b0;
    snap_clear_i = 1'b0;
    ev_v_i       = '0;
  endtask

  task automatic beat_chk(input int b, input logic [31:0] tag, input logic [31:0] t);
    chk($sformatf("rd_v_b%0d", b),     64'(rd_v_o),       64'd1);
    chk($sformatf("bank_b%0d", b),     64'(rd_bank_o),    64'(b / 6));
    chk($sformatf("event_b%0d", b),    64'(rd_event_o),   64'(b % 6));
    chk($sformatf("count_b%0d", b),    64'(rd_count_o),   64'(exp_c[b]));
    chk($sformatf("sat_b%0d", b),      64'(rd_sat_o),     64'(exp_s[b]));
    chk($sformatf("last_b%0d", b),     64'(rd_last_o),    64'(b == N - 1));
    chk($sformatf("tag_b%0d", b),      64'(rd_tag_o),     64'(tag));
    chk($sformatf("time_b%0d", b),     64'(rd_time_o),    64'(t));
    chk($sformatf("snap_rdy_b%0d", b), 64'(snap_ready_o), 64'd0);
  endtask

  // stall_at < 0 disables the backpressure window
  task automatic drain(input logic [31:0] tag, input logic [31:0] t,
                       input int stall_at, input int stall_n, input int stall_ev);
    rd_ready_i = 1'b1;
    for (int b = 0; b < N; b++) begin
      if (b == stall_at) begin
        rd_ready_i = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          ev_v_i = N'(1) << stall_ev;
          beat_chk(b, tag, t);
          tick();
        end
        ev_v_i     = '0;
        rd_ready_i = 1'b1;
      end
      beat_chk(b, tag, t);
      tick();
    end
    chk("rd_v_after_drain", 64'(rd_v_o), 64'd0);
    chk("snap_rdy_after_drain", 64'(snap_ready_o), 64'd1);
  endtask

  initial begin
    reset_n_i    = 1'b0;
    ev_v_i       = '0;
    snap_v_i     = 1'b0;
    snap_clear_i = 1'b0;
    snap_tag_i   = '0;
    rd_ready_i   = 1'b0;
    tick();
    tick();
    chk("rst_rd_v",     64'(rd_v_o),       64'd0);
    chk("rst_rd_last",  64'(rd_last_o),    64'd0);
    chk("rst_count",    64'(rd_count_o),   64'd0);
    chk("rst_bank",     64'(rd_bank_o),    64'd0);
    chk("rst_event",    64'(rd_event_o),   64'd0);
    chk("rst_sat",      64'(rd_sat_o),     64'd0);
    chk("rst_tag",      64'(rd_tag_o),     64'd0);
    chk("rst_time",     64'(rd_time_o),    64'd0);
    chk("rst_snap_rdy", 64'(snap_ready_o), 64'd1);
    reset_n_i = 1'b1;
    tick();

    // basic count: bank1/ld x5, bank0/dma_wr x3
    pulse(6, 5);
    pulse(5, 3);
    snap(32'hA5, 1'b1, '0, tm);
    zero_exp();
    exp_c[6] = 5;
    exp_c[5] = 3;
    drain(32'hA5, tm, -1, 0, 0);

    // saturation on bank0/st, then clear, then one more pulse
    pulse(1, 300);
    snap(32'h11, 1'b0, '0, tm);
    zero_exp();
    exp_c[1] = 255;
    exp_s[1] = 1'b1;
    drain(32'h11, tm, -1, 0, 0);
    snap(32'h12, 1'b1, '0, tm);
    drain(32'h12, tm, -1, 0, 0);
    pulse(1, 1);
    snap(32'h13, 1'b1, '0, tm);
    zero_exp();
    exp_c[1] = 1;
    drain(32'h13, tm, -1, 0, 0);

    // same-cycle clear with a bank0/ld event
    pulse(0, 7);
    snap(32'h21, 1'b1, N'(1), tm);
    zero_exp();
    exp_c[0] = 7;
    drain(32'h21, tm, -1, 0, 0);
    snap(32'h22, 1'b1, '0, tm);
    zero_exp();
    exp_c[0] = 1;
    // backpressure on beat 3 for 10 cycles while bank0/st_miss pulses
    drain(32'h22, tm, 3, 10, 3);
    snap(32'h23, 1'b1, '0, tm);
    zero_exp();
    exp_c[3] = 10;
    drain(32'h23, tm, -1, 0, 0);

    // request held during DRAIN is taken only after the stream ends
    snap(32'h1, 1'b1, '0, tm);
    snap_v_i   = 1'b1;
    snap_tag_i = 32'h2;
    zero_exp();
    drain(32'h1, tm, -1, 0, 0);
    tm = global_ctr_i;
    tick();
    snap_v_i = 1'b0;
    drain(32'h2, tm, -1, 0, 0);

    // asynchronous reset while beat 4 is presented
    pulse(8, 2);
    snap(32'h3, 1'b0, '0, tm);
    rd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("pre_rst_event", 64'(rd_event_o), 64'd4);
    chk("pre_rst_rd_v",  64'(rd_v_o),     64'd1);
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_rd_v",     64'(rd_v_o),       64'd0);
    chk("mid_rst_snap_rdy", 64'(snap_ready_o), 64'd1);
    chk("mid_rst_count",    64'(rd_count_o),   64'd0);
    chk("mid_rst_event",    64'(rd_event_o),   64'd0);
    chk("mid_rst_tag",      64'(rd_tag_o),     64'd0);
    chk("mid_rst_last",     64'(rd_last_o),    64'd0);
    tick();
    reset_n_i = 1'b1;
    tick();
    snap(32'h4, 1'b0, '0, tm);
    zero_exp();
    drain(32'h4, tm, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vcache_perf_counter_bank.md
# vcache_perf_counter_bank

Synthesizable event-counter bank for a multi-bank vcache. It counts six event types per bank: load, store, load miss, store miss, DMA read request and DMA write request. On request it freezes an atomic snapshot of every counter, with a tag and a timestamp, and streams the snapshot out one counter per beat over a valid/ready interface. It sits beside the vcache banks and feeds a host-visible stats path, replacing simulation-only file logging with hardware readout.

## Interface
- `num_banks_p`, default 4: number of vcache banks monitored; must be ≥1.
- `ctr_width_p`, default 32: width of each counter; must be ≥2.
- `tag_width_p`, default 32: width of the snapshot tag.
- `bank_id_width_lp`, derived: `max(1, $clog2(num_banks_p))`.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `ev_v_i`  in  `6*num_banks_p`  one-cycle event pulses. Bit `b*6+e` is bank `b`, event `e`. Event codes: 0=ld, 1=st, 2=ld_miss, 3=st_miss, 4=dma_rd, 5=dma_wr.
- `global_ctr_i`  in  32  free-running timestamp.
- `snap_v_i`  in  1  snapshot request.
- `snap_clear_i`  in  1  clear live counters on the accepted snapshot.
- `snap_tag_i`  in  `tag_width_p`  tag attached to the snapshot.
- `snap_ready_o`  out  1  snapshot request can be accepted.
- `rd_v_o`  out  1  readout beat valid.
- `rd_ready_i`  in  1  consumer accepts the beat.
- `rd_bank_o`  out  `bank_id_width_lp`  bank index of the beat.
- `rd_event_o`  out  3  event code of the beat.
- `rd_count_o`  out  `ctr_width_p`  snapshotted count.
- `rd_sat_o`  out  1  counter saturated during its epoch.
- `rd_tag_o`  out  `tag_width_p`  captured tag.
- `rd_time_o`  out  32  `global_ctr_i` captured at acceptance.
- `rd_last_o`  out  1  final beat of the snapshot.

## Operation
- Live counters: `6*num_banks_p` counters of `ctr_width_p` bits, each with a sticky `sat` flag.
  - On `ev_v_i[i]=1` the counter increments by 1.
  - At all-ones it holds at all-ones and sets `sat`. It never wraps.
- Snapshot acceptance: `snap_v_i & snap_ready_o` at a rising edge.
  - Every counter and `sat` flag is copied to shadow registers; `snap_tag_i` and `global_ctr_i` are latched.
  - The shadow holds the live values before that cycle's events are applied.
  - Without clear, that cycle's events add to live as normal.
  - With `snap_clear_i=1`, each live counter becomes `ev_v_i[i]` (0 or 1) and every `sat` is cleared.
- Live counting never stalls, including while the snapshot is draining.
- FSM states:
  - IDLE: `snap_ready_o=1`, `rd_v_o=0`. An accepted snapshot moves to DRAIN with index 0.
  - DRAIN: `snap_ready_o=0`, `rd_v_o=1`, and the beat shows shadow entry `index`.
    - Ordering is bank-major, event-minor: `rd_bank_o=index/6`, `rd_event_o=index%6`.
    - A handshake (`rd_v_o & rd_ready_i`) increments `index`.
    - The handshake on `index = 6*num_banks_p-1` (where `rd_last_o=1`) returns to IDLE.
- `snap_v_i` during DRAIN is not accepted and has no effect; the requester must hold it.
- `rd_tag_o` and `rd_time_o` are constant across all beats of one snapshot.

## Timing
- Reset (`reset_n_i=0`, asynchronous), values also held while asserted:
  - State IDLE, index 0.
  - All live and shadow counters, `sat` flags, tag and time registers are 0.
  - Outputs: `rd_v_o=0`, `rd_last_o=0`, `rd_count_o=0`, `rd_bank_o=0`, `rd_event_o=0`, `rd_sat_o=0`, `rd_tag_o=0`, `rd_time_o=0`, `snap_ready_o=1`.
- Reset mid-DRAIN aborts the stream immediately: `rd_v_o` drops asynchronously and no partial resume occurs.
- Event latency: an event at edge T is visible in the live count after T. It appears in a snapshot accepted at T+1 or later.
- Snapshot accepted at edge T: `rd_v_o=1` with beat 0 in the cycle after T.
- Beat stability: while `rd_v_o & ~rd_ready_i`, all `rd_*` outputs hold stable.
- Throughput and turnaround:
  - With `rd_ready_i` held high, one beat per cycle, so DRAIN lasts `6*num_banks_p` cycles.
  - `snap_ready_o` returns to 1 in the cycle after the last handshake.
  - The minimum snapshot period is `6*num_banks_p+1` cycles.
- All outputs are registered or decoded from state and shadow registers only. There is no combinational path from inputs to outputs.

## Test plan
1. Basic count, `num_banks_p=2`, `ctr_width_p=8`:
   - Stimulus: pulse bank1/ld 5 times and bank0/dma_wr 3 times, then snapshot with tag `0xA5` and `rd_ready_i=1`.
   - Required: 12 beats. Beat 6 (bank1, ev0) has count 5 and beat 5 (bank0, ev5) has count 3; all others are 0. `rd_last_o` is high only on beat 11, and every beat carries `rd_tag_o=0xA5`.
2. Saturation, `ctr_width_p=8`:
   - Stimulus: 300 bank0/st pulses, then a snapshot.
   - Required: beat 1 shows count 255 with `rd_sat_o=1`.
   - Follow-up: a second snapshot with `snap_clear_i=1`, then one more st pulse and a third snapshot. Beat 1 of the third snapshot shows count 1 with `rd_sat_o=0`.
3. Same-cycle clear:
   - Stimulus: count 7 on bank0/ld, then assert `snap_v_i`, `snap_clear_i` and `ev_v_i[0]` in the same cycle. Take the next snapshot with no further events.
   - Required: the first snapshot shows 7 and the next shows 1.
4. Backpressure:
   - Stimulus: hold `rd_ready_i=0` for 10 cycles on beat 3 while bank0/st_miss pulses continuously.
   - Required: beat 3 outputs stay stable, and a later snapshot reflects all of those pulses.
5. Busy request:
   - Stimulus: assert `snap_v_i` with tag `0x2` during DRAIN.
   - Required: `snap_ready_o=0` until one cycle after the last beat. The held request is then accepted, and its stream carries tag `0x2` and `rd_time_o` equal to the acceptance cycle's `global_ctr_i`.
6. Reset mid-DRAIN:
   - Stimulus: deassert `reset_n_i` at beat 4 with no clock edge.
   - Required: `rd_v_o=0` and `snap_ready_o=1` immediately, and all counts read 0 on the next snapshot.
